// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues PC reads to a one-cycle synchronous instruction
// memory and buffers {pc, inst} pairs for decode behind a credit-based stall.
module inst_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_ce_i,
  output logic              stall_o,
  output logic              imem_ce_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [DATA_W-1:0] imem_data_i,
  input  logic              flush_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = PTR_W + 2;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return ptr + PTR_W'(1'b1);
  endfunction

  logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
  logic [DATA_W-1:0] inst_mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              inflight_r;
  logic [ADDR_W-1:0] req_pc_r;

  logic              valid_s;
  logic              pop_s;
  logic              push_s;
  logic              issue_s;
  logic              stall_s;
  logic [OCC_W-1:0]  occ_s;
  logic [CNT_W-1:0]  count_nxt_s;

  // Handshake, credit and issue decisions; occupancy counts the same-cycle pop as freed space.
  always_comb begin
    valid_s = (count_r != {CNT_W{1'b0}});
    pop_s   = valid_s & id_ready_i;
    occ_s   = {1'b0, count_r}
            + {{(OCC_W-1){1'b0}}, inflight_r}
            - {{(OCC_W-1){1'b0}}, pop_s};
    stall_s = pc_ce_i & (occ_s >= DEPTH_OCC);
    issue_s = pc_ce_i & ~flush_i & ~stall_s;
    push_s  = inflight_r & ~flush_i;
  end

  // Next occupancy; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Control state: pointers, occupancy and the outstanding memory request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      inflight_r <= 1'b0;
      req_pc_r   <= {ADDR_W{1'b0}};
    end else if (flush_i) begin
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      inflight_r <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      inflight_r <= issue_s;
      if (issue_s) begin
        req_pc_r <= pc_i;
      end
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

  // Entry storage; returning memory data is paired with the PC that requested it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]   <= {ADDR_W{1'b0}};
        inst_mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      pc_mem_r[wr_ptr_r]   <= req_pc_r;
      inst_mem_r[wr_ptr_r] <= imem_data_i;
    end
  end

  assign stall_o     = stall_s;
  assign imem_ce_o   = issue_s & rst;
  assign imem_addr_o = pc_i;
  assign id_valid_o  = valid_s;
  assign id_pc_o     = pc_mem_r[rd_ptr_r];
  assign id_inst_o   = inst_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a synchronous memory model returns base + addr
// one cycle after each read; each task checks its scenario cycle by cycle.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_ce_i;
  logic        stall_o;
  logic        imem_ce_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data;
  logic        flush_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  logic [31:0] mem_base;
  int          errors = 0;
  int          checks = 0;

  inst_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_ce_i(pc_ce_i), .stall_o(stall_o),
    .imem_ce_o(imem_ce_o), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data),
    .flush_i(flush_i), .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem_base + imem_addr_o;

  // A push into a full FIFO must always coincide with a pop.
  always @(posedge clk) begin
    if (rst === 1'b1 && dut.inflight_r === 1'b1 && flush_i === 1'b0 && dut.count_r === 2'd2) begin
      checks++;
      if (!(id_valid_o && id_ready_i)) begin
        errors++;
        $display("FAIL full_push: push at count=2 without pop at %0t", $time);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; pc_ce_i = 1'b1; pc_i = 32'h44; flush_i = 1'b0; id_ready_i = 1'b0;
    mem_base = 32'h0;
    #1;
    tick();
    #1;
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", id_valid_o); end
    checks++; if (id_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", id_pc_o); end
    checks++; if (id_inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h want 0", id_inst_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall_o); end
    checks++; if (imem_ce_o !== 1'b0) begin errors++; $display("FAIL rst_ce: got %b want 0", imem_ce_o); end
    @(negedge clk);
    rst = 1'b1; pc_ce_i = 1'b0;
  endtask

  task automatic test_streaming;
    mem_base = 32'h1000_0000; id_ready_i = 1'b1; pc_ce_i = 1'b0;
    #1;
    checks++; if (imem_ce_o !== 1'b0) begin errors++; $display("FAIL stream_idle_ce: got %b want 0", imem_ce_o); end
    tick();
    for (int c = 0; c < 13; c++) begin
      pc_ce_i = (c < 10);
      pc_i = 32'(4 * c);
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL stream_stall c=%0d: got %b want 0", c, stall_o); end
      if (c < 10) begin
        checks++; if (imem_ce_o !== 1'b1 || imem_addr_o !== 32'(4 * c)) begin
          errors++; $display("FAIL stream_issue c=%0d: got ce=%b addr=%h want 1 %h", c, imem_ce_o, imem_addr_o, 4 * c);
        end
      end
      if (c >= 2 && c < 12) begin
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'(4 * (c - 2)) || id_inst_o !== 32'h1000_0000 + 32'(4 * (c - 2))) begin
          errors++; $display("FAIL stream_head c=%0d: got %b %h %h want 1 %h %h", c, id_valid_o, id_pc_o, id_inst_o,
                             4 * (c - 2), 32'h1000_0000 + 32'(4 * (c - 2)));
        end
      end else begin
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL stream_empty c=%0d: got %b want 0", c, id_valid_o); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure;
    mem_base = 32'h1000_0000; id_ready_i = 1'b0; pc_ce_i = 1'b1;
    pc_i = 32'h20; #1;
    checks++; if (stall_o !== 1'b0 || imem_ce_o !== 1'b1) begin errors++; $display("FAIL bp_a: got stall=%b ce=%b want 0 1", stall_o, imem_ce_o); end
    tick();
    pc_i = 32'h24; #1;
    checks++; if (stall_o !== 1'b0 || imem_ce_o !== 1'b1) begin errors++; $display("FAIL bp_b: got stall=%b ce=%b want 0 1", stall_o, imem_ce_o); end
    tick();
    pc_i = 32'h28; #1;
    checks++; if (stall_o !== 1'b1 || imem_ce_o !== 1'b0) begin errors++; $display("FAIL bp_c: got stall=%b ce=%b want 1 0", stall_o, imem_ce_o); end
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h20) begin errors++; $display("FAIL bp_c_head: got %b %h want 1 20", id_valid_o, id_pc_o); end
    tick();
    #1;
    checks++; if (stall_o !== 1'b1 || dut.count_r !== 2'd2) begin errors++; $display("FAIL bp_d: got stall=%b count=%0d want 1 2", stall_o, dut.count_r); end
    tick();
    id_ready_i = 1'b1; #1;
    checks++; if (id_pc_o !== 32'h20 || id_inst_o !== 32'h1000_0020) begin errors++; $display("FAIL bp_e_head: got %h %h want 20 10000020", id_pc_o, id_inst_o); end
    checks++; if (stall_o !== 1'b0 || imem_ce_o !== 1'b1 || imem_addr_o !== 32'h28) begin
      errors++; $display("FAIL bp_e_issue: got stall=%b ce=%b addr=%h want 0 1 28", stall_o, imem_ce_o, imem_addr_o);
    end
    tick();
    pc_ce_i = 1'b0; #1;
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h24 || id_inst_o !== 32'h1000_0024) begin
      errors++; $display("FAIL bp_f: got %b %h %h want 1 24 10000024", id_valid_o, id_pc_o, id_inst_o);
    end
    tick(); #1;
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h28) begin errors++; $display("FAIL bp_g: got %b %h want 1 28", id_valid_o, id_pc_o); end
    tick(); #1;
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL bp_h: got %b want 0", id_valid_o); end
  endtask

  task automatic test_flush;
    mem_base = 32'h2000_0000; id_ready_i = 1'b0; pc_ce_i = 1'b1;
    pc_i = 32'h40; tick();
    pc_i = 32'h44; tick();
    flush_i = 1'b1; id_ready_i = 1'b1; pc_i = 32'h48; #1;
    checks++; if (imem_ce_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL flush_ce: got ce=%b stall=%b want 0 0", imem_ce_o, stall_o); end
    tick();
    flush_i = 1'b0; pc_i = 32'h80; #1;
    checks++; if (id_valid_o !== 1'b0 || dut.count_r !== 2'd0) begin errors++; $display("FAIL flush_clear: got valid=%b count=%0d want 0 0", id_valid_o, dut.count_r); end
    checks++; if (imem_ce_o !== 1'b1) begin errors++; $display("FAIL flush_reissue: got %b want 1", imem_ce_o); end
    tick();
    pc_i = 32'h84; #1;
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL flush_gap: got %b want 0", id_valid_o); end
    tick();
    pc_ce_i = 1'b0; #1;
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h80 || id_inst_o !== 32'h2000_0080) begin
      errors++; $display("FAIL flush_first: got %b %h %h want 1 80 20000080", id_valid_o, id_pc_o, id_inst_o);
    end
    tick(); #1;
    checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h84) begin errors++; $display("FAIL flush_second: got %b %h want 1 84", id_valid_o, id_pc_o); end
    tick(); #1;
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drain: got %b want 0", id_valid_o); end
  endtask

  task automatic test_wrap;
    logic [7:0]  pat;
    logic [31:0] cur_pc;
    logic [31:0] exp_pc;
    int          issued;
    int          popped;
    bit          stall_seen;
    pat = 8'b1011_0110; cur_pc = 32'h100; exp_pc = 32'h100;
    issued = 0; popped = 0; stall_seen = 1'b0;
    mem_base = 32'h4000_0000;
    for (int c = 0; c < 60; c++) begin
      id_ready_i = pat[c % 8];
      pc_ce_i = (issued < 12);
      pc_i = cur_pc;
      #1;
      if (stall_o) stall_seen = 1'b1;
      if (id_valid_o && id_ready_i) begin
        checks++; if (id_pc_o !== exp_pc || id_inst_o !== 32'h4000_0000 + exp_pc) begin
          errors++; $display("FAIL wrap_order: got %h %h want %h %h", id_pc_o, id_inst_o, exp_pc, 32'h4000_0000 + exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        popped++;
      end
      if (pc_ce_i && !stall_o) begin
        cur_pc = cur_pc + 32'd4;
        issued++;
      end
      tick();
    end
    checks++; if (popped != 12) begin errors++; $display("FAIL wrap_count: got %0d want 12", popped); end
    checks++; if (stall_seen !== 1'b1) begin errors++; $display("FAIL wrap_stall: got %b want 1", stall_seen); end
  endtask

  task automatic test_async_reset;
    mem_base = 32'h5000_0000; id_ready_i = 1'b1; pc_ce_i = 1'b1;
    pc_i = 32'h200; tick();
    pc_i = 32'h204; tick();
    pc_i = 32'h208; #1;
    checks++; if (id_valid_o !== 1'b1 || dut.inflight_r !== 1'b1) begin errors++; $display("FAIL ar_pre: got valid=%b inflight=%b want 1 1", id_valid_o, dut.inflight_r); end
    #2 rst = 1'b0;
    #1;
    checks++; if (id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || id_inst_o !== 32'h0 || stall_o !== 1'b0 || imem_ce_o !== 1'b0) begin
      errors++; $display("FAIL ar_outputs: got %b %h %h %b %b want 0 0 0 0 0", id_valid_o, id_pc_o, id_inst_o, stall_o, imem_ce_o);
    end
    @(negedge clk);
    rst = 1'b1; mem_base = 32'h6000_0000;
    for (int c = 0; c < 5; c++) begin
      pc_ce_i = (c < 3);
      pc_i = 32'h300 + 32'(4 * c);
      #1;
      if (c < 2) begin
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL ar_gap c=%0d: got %b want 0", c, id_valid_o); end
      end else begin
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h300 + 32'(4 * (c - 2)) || id_inst_o !== 32'h6000_0300 + 32'(4 * (c - 2))) begin
          errors++; $display("FAIL ar_stream c=%0d: got %b %h %h want 1 %h %h", c, id_valid_o, id_pc_o, id_inst_o,
                             32'h300 + 32'(4 * (c - 2)), 32'h6000_0300 + 32'(4 * (c - 2)));
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
